// File: rtl/fifo_pack_wrapper.sv
// Width up-converting FIFO: byte writes in, little-endian 16-bit words out,
// first-word-fall-through. Circular queue over a byte-wide register file.
module fifo_pack_wrapper #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       read,
  input  logic [DATA_WIDTH-1:0]      w_data,
  output logic [2*DATA_WIDTH-1:0]    r_data,
  output logic                       full_flag,
  output logic                       empty_flag,
  output logic [ADDRESS_WIDTH:0]     fill_level
);

  localparam int                   DEPTH      = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] WORD_BYTES = (ADDRESS_WIDTH + 1)'(2);

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_w_ptr;
  logic [ADDRESS_WIDTH-1:0] r_r_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;

  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic [ADDRESS_WIDTH-1:0] w_r_ptr_hi;
  logic [ADDRESS_WIDTH:0]   w_count_inc;
  logic [ADDRESS_WIDTH:0]   w_count_dec;

  assign full_flag  = (r_count == FULL_COUNT);
  assign empty_flag = (r_count < WORD_BYTES);
  assign fill_level = r_count;

  // Both accepts look only at the registered flags, so a read never frees
  // room for a same-cycle write.
  assign w_wr_acc = write & ~full_flag;
  assign w_rd_acc = read  & ~empty_flag;

  // r_ptr is always even, so the upper byte of a word never wraps.
  assign w_r_ptr_hi = r_r_ptr + ADDRESS_WIDTH'(1);
  assign r_data     = {r_mem[w_r_ptr_hi], r_mem[r_r_ptr]};

  assign w_count_inc = (ADDRESS_WIDTH + 1)'(w_wr_acc);
  assign w_count_dec = w_rd_acc ? WORD_BYTES : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_w_ptr <= r_w_ptr + ADDRESS_WIDTH'(1);
      if (w_rd_acc) r_r_ptr <= r_r_ptr + ADDRESS_WIDTH'(2);
      r_count <= r_count + w_count_inc - w_count_dec;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count alone define which entries hold valid data.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_w_ptr] <= w_data;
  end

endmodule

// File: tb/tb_fifo_pack_wrapper.sv
// Self-checking bench for fifo_pack_wrapper: byte scoreboard queue, words
// compared as they are popped, flags compared against the queue depth.
module tb_fifo_pack_wrapper;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            write;
  logic            read;
  logic [DW-1:0]   w_data;
  logic [2*DW-1:0] r_data;
  logic            full_flag;
  logic            empty_flag;
  logic [AW:0]     fill_level;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  fifo_pack_wrapper #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .read       (read),
    .w_data     (w_data),
    .r_data     (r_data),
    .full_flag  (full_flag),
    .empty_flag (empty_flag),
    .fill_level (fill_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_fill"},  32'(fill_level), 32'(sb.size()));
    check({tag, "_empty"}, 32'(empty_flag), 32'(sb.size() < 2));
    check({tag, "_full"},  32'(full_flag),  32'(sb.size() == DEPTH));
  endtask

  // Called at posedge+1; accept decisions come from the scoreboard depth.
  task automatic cycle(input logic wr, input logic rd, input logic [7:0] d, input string tag);
    logic wa;
    logic ra;
    write  = wr;
    read   = rd;
    w_data = d;
    wa = wr && (sb.size() < DEPTH);
    ra = rd && (sb.size() >= 2);
    if (ra) begin
      check({tag, "_word"}, 32'(r_data), {16'h0, sb[1], sb[0]});
      void'(sb.pop_front());
      void'(sb.pop_front());
    end
    if (wa) sb.push_back(d);
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
    check_flags(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    reset  = 1'b1;
    write  = 1'b0;
    read   = 1'b0;
    w_data = '0;
    #12 reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset state, first word assembly, pop
    check("rst_empty", 32'(empty_flag), 32'd1);
    check("rst_full",  32'(full_flag),  32'd0);
    check("rst_fill",  32'(fill_level), 32'd0);
    cycle(1'b1, 1'b0, 8'hAB, "t1_w1");
    check("t1_empty_one_byte", 32'(empty_flag), 32'd1);
    check("t1_fill_one_byte",  32'(fill_level), 32'd1);
    cycle(1'b1, 1'b0, 8'hCD, "t1_w2");
    check("t1_empty_word", 32'(empty_flag), 32'd0);
    check("t1_head",       32'(r_data),     32'h0000CDAB);
    cycle(1'b0, 1'b1, 8'h00, "t1_rd");
    check("t1_empty_after_rd", 32'(empty_flag), 32'd1);
    check("t1_fill_after_rd",  32'(fill_level), 32'd0);

    // 2: lone byte is not readable
    cycle(1'b1, 1'b0, 8'h11, "t2_w1");
    cycle(1'b0, 1'b1, 8'h00, "t2_rd_odd");
    check("t2_fill_odd", 32'(fill_level), 32'd1);
    cycle(1'b1, 1'b0, 8'h22, "t2_w2");
    check("t2_head", 32'(r_data), 32'h00002211);
    cycle(1'b0, 1'b1, 8'h00, "t2_rd");

    // 3: fill, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i), "t3_fill");
    check("t3_full",      32'(full_flag),  32'd1);
    check("t3_fill_full", 32'(fill_level), 32'd16);
    cycle(1'b1, 1'b0, 8'hFF, "t3_ovf");
    check("t3_fill_ovf", 32'(fill_level), 32'd16);
    for (int k = 0; k < DEPTH / 2; k++) begin
      check("t3_word_pattern", 32'(r_data), {16'h0, 8'(2 * k + 1), 8'(2 * k)});
      cycle(1'b0, 1'b1, 8'h00, "t3_rd");
    end
    check("t3_empty_end", 32'(empty_flag), 32'd1);

    // 4: interleaved traffic across several pointer wraps
    pat = 8'h40;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, i[0], pat, "t4_mix");
      pat = pat + 8'd1;
    end
    for (int i = 0; i < DEPTH && sb.size() >= 2; i++) cycle(1'b0, 1'b1, 8'h00, "t4_drain");
    check("t4_fill_drained", 32'(fill_level), 32'd0);

    // 5: simultaneous read/write at full and mid-level
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'h80 + 8'(i), "t5_fill");
    cycle(1'b1, 1'b1, 8'h77, "t5_full_rw");
    check("t5_fill_after_full_rw", 32'(fill_level), 32'd14);
    check("t5_full_after_full_rw", 32'(full_flag),  32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "t5_rd");
    check("t5_fill_six", 32'(fill_level), 32'd6);
    cycle(1'b1, 1'b1, 8'h5A, "t5_mid_rw");
    check("t5_fill_five", 32'(fill_level), 32'd5);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h00, "t5_drain");

    // 6: asynchronous reset between edges
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i), "t6_fill");
    check("t6_fill_nine", 32'(fill_level), 32'd9);
    #2 reset = 1'b1;
    #1;
    check("t6_async_fill",  32'(fill_level), 32'd0);
    check("t6_async_empty", 32'(empty_flag), 32'd1);
    check("t6_async_full",  32'(full_flag),  32'd0);
    sb.delete();
    #2 reset = 1'b0;
    cycle(1'b1, 1'b0, 8'hA1, "t6_w1");
    cycle(1'b1, 1'b0, 8'hB2, "t6_w2");
    check("t6_head_new", 32'(r_data), 32'h0000B2A1);
    cycle(1'b0, 1'b1, 8'h00, "t6_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
